// File: rtl/ex_muldiv_sequencer.sv
// Multi-cycle RV32M sequencer: radix-2 shift-add multiply and restoring divide,
// fixed 33-edge latency from start to the done pulse, with flush abort and pipeline stall.
module ex_muldiv_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] m_q, m_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_q, neg_d;
  logic [31:0] result_q, result_d;

  // Operand sign handling at capture time
  logic        sgn_a, sgn_b, a_neg, b_neg;
  logic [31:0] mag_a, mag_b;

  always_comb begin
    sgn_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
            (funct3 == 3'b100) || (funct3 == 3'b110);
    sgn_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg = sgn_a & operand_a[31];
    b_neg = sgn_b & operand_b[31];
    mag_a = a_neg ? (32'd0 - operand_a) : operand_a;
    mag_b = b_neg ? (32'd0 - operand_b) : operand_b;
  end

  // One iteration. MUL: acc = {partial_hi, multiplier}, shift right.
  // DIV: acc = {remainder, dividend/quotient}, shift left with restoring subtract.
  logic [32:0] mul_sum, div_diff;
  logic [63:0] step, mul_fix;
  logic [31:0] quo_fix, rem_fix, fin;

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
    div_diff = acc_q[63:31] - {1'b0, m_q};
    if (op_q[2])
      step = div_diff[32] ? {acc_q[62:0], 1'b0} : {div_diff[31:0], acc_q[30:0], 1'b1};
    else
      step = {mul_sum, acc_q[31:1]};
    mul_fix = neg_q ? (64'd0 - step) : step;
    quo_fix = neg_q ? (32'd0 - step[31:0]) : step[31:0];
    rem_fix = neg_q ? (32'd0 - step[63:32]) : step[63:32];
    case (op_q)
      3'b000:                 fin = mul_fix[31:0];
      3'b001, 3'b010, 3'b011: fin = mul_fix[63:32];
      3'b100, 3'b101:         fin = quo_fix;
      default:                fin = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    m_d      = m_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d  = funct3;
          cnt_d = 5'd0;
          if (funct3[2]) begin
            m_d   = mag_b;
            acc_d = {32'd0, mag_a};
            // A zero divisor yields an all-ones quotient that must not be sign-corrected
            neg_d = funct3[1] ? a_neg : ((a_neg ^ b_neg) & (|operand_b));
          end else begin
            m_d   = mag_a;
            acc_d = {32'd0, mag_b};
            neg_d = a_neg ^ b_neg;
          end
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_d = fin;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 3'd0;
      m_q      <= 32'd0;
      acc_q    <= 64'd0;
      neg_q    <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign stall  = ((state_q == S_IDLE) && start && !flush) || (state_q == S_CALC);
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: doc/ex_muldiv_sequencer.md
EX_MULDIV_SEQUENCER -- requirements
Module: ex_muldiv_sequencer

Interface
REQ-001 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-002 Ports SHALL be as follows:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  request a multi-cycle M-extension operation
- funct3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operand_a  in  32  rs1 (already forwarded)
- operand_b  in  32  rs2 (already forwarded)
- flush  in  1  abort the current operation (branch/jump redirect)
- stall  out  1  hold the IF/ID/EX pipeline registers
- busy  out  1  state != IDLE
- done  out  1  one-cycle result-valid pulse
- result  out  32  operation result

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-004 In IDLE, with start=1 and flush=0, the rising edge SHALL do all of the following:
- capture funct3, operand_a and operand_b;
- load the operand magnitudes and result-sign flags;
- clear the 5-bit iteration counter;
- enter CALC.
REQ-005 In CALC, each edge SHALL perform one radix-2 iteration and increment the counter.
- MUL family: shift-add into a 64-bit accumulator.
- DIV family: restoring shift-subtract into a 32-bit quotient and 32-bit remainder.
REQ-006 After the 32nd CALC iteration (counter==31), the FSM SHALL enter DONE.
REQ-007 Latency SHALL be fixed for all ops, including the special cases below: done=1 on the 33rd rising edge, counting the edge that samples start as edge 1.
REQ-008 In DONE:
- done SHALL be 1 for exactly one cycle, with result valid;
- the next edge SHALL return the FSM to IDLE.
REQ-009 result SHALL be registered, and it SHALL hold its value until the next DONE.
REQ-010 Signed operands SHALL be converted to magnitudes and the final value sign-corrected.
- MULH: both operands signed.
- MULHSU: rs1 signed, rs2 unsigned.
- DIV/REM: both operands signed.
- Quotient sign = sign(a) XOR sign(b).
- Remainder sign = sign(a).
REQ-011 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32] of the full 64-bit signed/unsigned product.
REQ-012 Divide by zero (operand_b==0) SHALL return:
- DIV/DIVU: 0xFFFFFFFF;
- REM/REMU: operand_a unchanged.
REQ-013 Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF) SHALL return:
- DIV: 0x80000000;
- REM: 0x00000000.
REQ-014 stall SHALL be combinational and equal to (IDLE and start and !flush) or CALC; it SHALL be 0 in DONE, so that EX advances on the done cycle.
REQ-015 busy SHALL be 1 in CALC and DONE and 0 in IDLE.
REQ-016 start SHALL be ignored while busy=1; in-flight operand and funct3 registers SHALL not change.
REQ-017 flush=1 in CALC or DONE SHALL move the FSM to IDLE on the next edge.
- done SHALL not pulse for the aborted op.
- result SHALL keep its prior value.
REQ-018 flush=1 together with start=1 in IDLE SHALL leave the FSM in IDLE; stall SHALL be 0 that cycle.
REQ-019 start may be asserted in the cycle after DONE (now IDLE), giving back-to-back ops with one idle cycle between done pulses.

Reset
REQ-020 rst_n=0 SHALL immediately, asynchronously, force all of the following:
- state=IDLE;
- counter=0;
- result=0x00000000;
- accumulators=0;
- done=0, busy=0.
REQ-021 Reset asserted mid-operation SHALL discard the operation; after release the block SHALL accept a new start normally.

Verification
REQ-022 The bench SHALL cover these MUL cases:
- MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB on edge 33; stall=1 for edges 1-32 and 0 at DONE.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-023 The bench SHALL cover these signed divide cases:
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD.
- REM with the same operands -> 0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000.
- REM with the same operands -> 0.
REQ-024 The bench SHALL cover divide by zero:
- DIVU a=100, b=0 -> 0xFFFFFFFF.
- REMU a=100, b=0 -> 100.
- DIV a=5, b=0 -> 0xFFFFFFFF.
REQ-025 The bench SHALL cover abort and ignored start:
- flush on edge 10 of a DIVU -> FSM in IDLE next cycle, no done pulse, result unchanged; a following MUL 3*4 -> 12.
- start pulsed mid-CALC -> ignored; the original result is correct.
REQ-026 The bench SHALL cover reset mid-operation: rst_n low during CALC edge 15 -> busy=0, result=0, done=0 immediately; after release, DIV 100/7 -> 14 on edge 33.
